spi_cmd_master: RTL
===================

# spi_cmd_master

Parametrised SPI master for serial flash command transactions: one opcode byte, an optional 24-bit address, then a programmable number of read bytes streamed out one byte at a time. It generalises the fixed RDID-only SPI reader to any single-opcode read command, with a programmable SCLK divider and multiple chip selects. It sits between the system controller (start/done handshake) and the board SPI pins.

## Interface
Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period; legal range is 1 to 255.
- NUM_CS, 1: number of chip-select outputs; legal range is 1 to 8.
- LEN_W, 8: width of rx_len; up to 2^LEN_W-1 read bytes per transaction.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- cmd  in  8  opcode, captured at start.
- rx_len  in  LEN_W  number of bytes to read, captured at start; 0 means a command-only transaction.
- cs_sel  in  clog2(NUM_CS) (min 1)  target device, captured at start.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse at transaction end.
- rx_data  out  8  last received byte, MSB first on the wire.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- SPICLK  out  1  serial clock, mode 0 (idles low).
- SPIMOSI  out  1  serial data out.
- SPIMISO  in  1  serial data in.
- chip_select  out  NUM_CS  active-low device selects.

## Operation
- Reset values: chip_select all 1s, SPICLK=0, SPIMOSI=0, busy=0, done=0, rx_valid=0, rx_data=8'h00, FSM in IDLE.
- FSM states and transitions:
  - IDLE: on start, go to CS_SETUP.
  - CS_SETUP: lasts CLK_DIV cycles, then SEND_CMD.
  - SEND_CMD: 8 bits, then SEND_ADDR if the address phase is enabled and addr_en=1; else RECV if rx_len≠0; else CS_HOLD.
  - SEND_ADDR: 24 bits, then RECV if rx_len≠0, else CS_HOLD.
  - RECV: runs until the byte counter reaches rx_len, then CS_HOLD.
  - CS_HOLD: lasts CLK_DIV cycles, then DONE.
  - DONE: 1 cycle, then IDLE.
- chip_select[cs_sel] is low from CS_SETUP through CS_HOLD inclusive. All other selects stay high.
- Shift order is MSB first. MOSI is valid at CS_SETUP entry for bit 7 and changes on each SPICLK falling edge thereafter. MOSI is 0 during RECV.
- MISO is sampled in the clk cycle in which SPICLK is driven high. After the 8th sample, rx_data is updated and rx_valid pulses on the next cycle.
- The byte counter is LEN_W bits wide and compares for equality only; there is no wrap-around.
- start while busy=1 is ignored; no queueing. cmd, rx_len and cs_sel are held in internal registers; input changes after acceptance have no effect.
- If cs_sel ≥ NUM_CS, the transaction runs with all chip selects high. The bus still toggles and done still pulses.
- reset_n low mid-transaction: all outputs return to their reset values immediately and asynchronously. No done pulse is issued.

## Timing
- One bit period is 2×CLK_DIV clk cycles. SPICLK is high for the second half of each bit.
- Transaction length from the start cycle to the done pulse, in cycles: 1 + CLK_DIV + 2·CLK_DIV·8·(1 + 3·A + rx_len) + CLK_DIV + 1, where A=1 when the address phase runs.
- SPICLK ends low before CS_HOLD begins, so there is no trailing edge while CS is asserted.
- The last rx_valid pulse precedes done by at least CLK_DIV cycles.
- done and busy fall in the same cycle. start is accepted again in the cycle after done.

## Configuration
- SPI_ADDR_PHASE_EN defined: adds input addr[23:0] and input addr_en, both captured at start. SEND_ADDR shifts addr MSB first when addr_en=1.
- SPI_ADDR_PHASE_EN undefined: these ports do not exist, SEND_ADDR is never entered, and A=0 in the timing formula.

## Test plan
- JEDEC ID read: CLK_DIV=2, cmd=8'h9F, rx_len=3, slave returns EF 40 18.
  - Required: MOSI carries 1001_1111, then three rx_valid pulses with rx_data EF, 40, 18.
  - Required: done at cycle 1+2+32·4+2+1 = 134 after start; chip_select[0] low throughout.
- Command only: cmd=8'h06, rx_len=0.
  - Required: exactly 8 SPICLK rising edges, no rx_valid, done at cycle 1+2+32+2+1 = 38.
- Address read (macro on): cmd=8'h03, addr=24'h012345, addr_en=1, rx_len=2, slave returns A5 5A.
  - Required: MOSI shows 03 01 23 45, rx_data is A5 then 5A, and 32 rising edges precede the first sample.
- Multi-CS and busy: NUM_CS=4, cs_sel=2.
  - Required: only chip_select[2] toggles.
  - Required: a second start pulsed mid-transaction is ignored; exactly one done is produced.
- Reset mid-RECV: assert reset_n low at byte 2 of 3.
  - Required: chip_select=all 1s and SPICLK=0 with no clk edge, no done pulse.
  - Required: the next start completes a normal transaction.
- Divider corner: CLK_DIV=1, rx_len=255, slave pattern counts 00..FE.
  - Required: 255 rx_valid pulses with matching data, SPICLK toggles every clk cycle, and the counter terminates with no wrap.

Source files
------------

// File: rtl/spi_cmd_master_if.sv
// Command-side handshake bundle between the system controller and spi_cmd_master.
// addr/addr_en exist only when SPI_ADDR_PHASE_EN is defined.
interface spi_cmd_master_if #(
  parameter int NUM_CS = 1,
  parameter int LEN_W  = 8
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic             start;
  logic [7:0]       cmd;
  logic [LEN_W-1:0] rx_len;
  logic [CS_W-1:0]  cs_sel;
`ifdef SPI_ADDR_PHASE_EN
  logic [23:0]      addr;
  logic             addr_en;
`endif
  logic             busy;
  logic             done;
  logic [7:0]       rx_data;
  logic             rx_valid;

`ifdef SPI_ADDR_PHASE_EN
  modport master (output start, cmd, rx_len, cs_sel, addr, addr_en,
                  input  busy, done, rx_data, rx_valid);
  modport slave  (input  start, cmd, rx_len, cs_sel, addr, addr_en,
                  output busy, done, rx_data, rx_valid);
`else
  modport master (output start, cmd, rx_len, cs_sel,
                  input  busy, done, rx_data, rx_valid);
  modport slave  (input  start, cmd, rx_len, cs_sel,
                  output busy, done, rx_data, rx_valid);
`endif
endinterface

// File: rtl/spi_cmd_master.sv
// Mode-0 SPI master: opcode, optional 24-bit address, then rx_len read bytes.
// Defining SPI_ADDR_PHASE_EN adds the address phase (addr/addr_en on the interface).
module spi_cmd_master #(
  parameter int CLK_DIV = 2,
  parameter int NUM_CS  = 1,
  parameter int LEN_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_cmd_master_if.slave   bus,
  output logic              SPICLK,
  output logic              SPIMOSI,
  input  logic              SPIMISO,
  output logic [NUM_CS-1:0] chip_select
);
  localparam int         CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SEND_CMD, SEND_ADDR, RECV, CS_HOLD, DONE
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       div_cnt;
  logic             half;
  logic [4:0]       bit_cnt;
  logic [LEN_W-1:0] byte_cnt, byte_nx, len_q;
  logic [31:0]      tx_sh;
  logic [6:0]       rx_sh;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic [NUM_CS-1:0] cs_q, cs_dec;
  logic [23:0]      addr_in;
  logic             addr_go;
  logic             accept, shifting, div_end, bit_end, rise, phase_last;

`ifdef SPI_ADDR_PHASE_EN
  logic addr_q;
  assign addr_go = addr_q;
  assign addr_in = bus.addr;
`else
  assign addr_go = 1'b0;
  assign addr_in = '0;
`endif

  assign accept     = (state == IDLE) && bus.start;
  assign shifting   = state inside {SEND_CMD, SEND_ADDR, RECV};
  assign div_end    = (div_cnt == DIV_LAST);
  // half=0 is the SCLK-low half of a bit; MISO is sampled on the edge that raises SCLK
  assign bit_end    = shifting && half && div_end;
  assign rise       = shifting && !half && div_end;
  assign phase_last = (state == SEND_ADDR) ? (bit_cnt == 5'd23) : (bit_cnt == 5'd7);
  assign byte_nx    = byte_cnt + 1'b1;

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign SPICLK       = half;
  assign SPIMOSI      = (state inside {CS_SETUP, SEND_CMD, SEND_ADDR}) && tx_sh[31];
  assign chip_select  = cs_q;

  // Out-of-range cs_sel decodes to all-high, so the transaction runs unselected
  always_comb begin
    cs_dec = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (bus.cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (bus.start) state_nx = CS_SETUP;
      CS_SETUP:  if (div_end) state_nx = SEND_CMD;
      SEND_CMD:
        if (bit_end && phase_last) begin
          if (addr_go)              state_nx = SEND_ADDR;
          else if (len_q != '0)     state_nx = RECV;
          else                      state_nx = CS_HOLD;
        end
      SEND_ADDR:
        if (bit_end && phase_last) state_nx = (len_q != '0) ? RECV : CS_HOLD;
      RECV:
        if (bit_end && phase_last && (byte_nx == len_q)) state_nx = CS_HOLD;
      CS_HOLD:   if (div_end) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      half       <= 1'b0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      len_q      <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cs_q       <= '1;
`ifdef SPI_ADDR_PHASE_EN
      addr_q     <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;

      if (state == IDLE || state == DONE || div_end) div_cnt <= '0;
      else                                           div_cnt <= div_cnt + 8'd1;

      if (!shifting)    half <= 1'b0;
      else if (div_end) half <= ~half;

      if (accept) begin
        tx_sh    <= {bus.cmd, addr_in};
        len_q    <= bus.rx_len;
        cs_q     <= cs_dec;
        bit_cnt  <= '0;
        byte_cnt <= '0;
`ifdef SPI_ADDR_PHASE_EN
        addr_q   <= bus.addr_en;
`endif
      end

      if (bit_end) begin
        tx_sh   <= {tx_sh[30:0], 1'b0};
        bit_cnt <= phase_last ? 5'd0 : bit_cnt + 5'd1;
        if (state == RECV && phase_last) byte_cnt <= byte_nx;
      end

      if (rise && state == RECV) begin
        rx_sh <= {rx_sh[5:0], SPIMISO};
        if (phase_last) begin
          rx_data_q  <= {rx_sh, SPIMISO};
          rx_valid_q <= 1'b1;
        end
      end

      if (state == CS_HOLD && div_end) cs_q <= '1;
    end
  end
endmodule
